dm_responder: RTL and testbench
===============================

# dm_responder

Memory-side responder for the ARVI data-memory interface. It is the slave end of the `DM_*` handshake driven by the core's load/store unit, and it sits between the datapath's data-memory port and a word-organised on-chip RAM. It latches each load or store request and counts a configurable access latency. It then performs the byte/half/word access selected by `f3`, with alignment and sign extension, and returns a one-cycle `data_ready` pulse.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `MEM_WORDS*4`.
- `LATENCY`, 2: cycles from request acceptance to `o_DM_data_ready`; legal range 1..15.

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-low.
- `i_DM_Addr`  in  32  byte address of the access.
- `i_DM_Wd`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `i_DM_f3`  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `i_DM_Wen`  in  1  store request.
- `i_DM_MemRead`  in  1  load request.
- `o_DM_data_ready`  out  1  one-cycle completion pulse.
- `o_DM_ReadData`  out  32  load result, extended to 32 bits; valid while `o_DM_data_ready`=1.
- `o_err`  out  1  pulses with `o_DM_data_ready` when the access was misaligned, out of range, or used an illegal `f3`.

## Operation
- States:
  - IDLE. A request is `i_DM_Wen | i_DM_MemRead`. On a request, latch addr/wd/f3/type. If the latched count equals 1, go to RESP; otherwise go to WAIT with count = LATENCY-1.
  - WAIT. Decrement the count each cycle. Go to RESP when the count reaches 1.
  - RESP. Assert `o_DM_data_ready` and go unconditionally back to IDLE.
- The request is sampled again in IDLE only. This gives one mandatory turnaround cycle, so a request held high across instruction boundaries (back-to-back loads) is serviced exactly once per instruction.
- Withdrawal: if both request lines are low in any WAIT cycle, return to IDLE. No write is performed and no ready pulse is issued.
- Write commit: the RAM write happens on the edge entering RESP, never earlier.
- Read capture: `o_DM_ReadData` is registered on the edge entering RESP. Outside RESP it is 0.
- Wen and MemRead both high: treat as a store; `o_DM_ReadData`=0.
- Address handling:
  - Word index = (addr - BASE_ADDR) >> 2.
  - Out of range means (addr - BASE_ADDR) ≥ MEM_WORDS*4, evaluated with unsigned 32-bit arithmetic.
- Byte enables for stores:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << addr[1:0]; addr[0] must be 0.
  - W: 4'b1111; addr[1:0] must be 00.
- Load extraction:
  - Shift the word right by 8*addr[1:0].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Errors: for a misaligned, out-of-range, or illegal-`f3` access (011, 110, 111, or BU/HU on a store), suppress the write, return ReadData=0, and still complete with ready + `o_err`.
- The RAM array is not reset.

## Timing
- Reset values: state IDLE, `o_DM_data_ready`=0, `o_DM_ReadData`=0, `o_err`=0, count 0.
- Latency: request first high in IDLE at cycle N gives a ready pulse at cycle N+LATENCY. The earliest next acceptance is cycle N+LATENCY+1.
- Ready is always exactly one cycle wide and driven from registers; there is no combinational path from inputs to outputs.
- Reset asserted mid-WAIT or mid-RESP: outputs clear immediately, there is no pulse, and a pending store is not written. A store already committed on the edge into RESP stays in the RAM.
- Throughput: one access per LATENCY+1 cycles with a continuously held request.

## Test plan
- LATENCY=2, SW addr 0x10 data 0xDEADBEEF, then LW 0x10. Ready appears 2 cycles after each request with a 1-cycle gap between them; the read returns 0xDEADBEEF and `o_err`=0.
- Sub-word access on word 0x10 = 0xDEADBEEF. LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF. Then SB 0x11 data 0x55 and LW 0x10 → 0xDEAD55EF.
- Error cases, each giving ready + `o_err` with ReadData 0 and RAM unchanged. LH 0x11 is misaligned. SW 0x12 is misaligned. LW `BASE_ADDR+MEM_WORDS*4` is out of range. LW with f3=011 is an illegal `f3`.
- Hold `i_DM_MemRead` high for 3 back-to-back loads changing address on each ready. Exactly 3 ready pulses, spaced LATENCY+1 cycles apart.
- Withdrawal and reset. SW withdrawn in the first WAIT cycle gives no pulse and no write. `i_rst` low during WAIT of SW 0x20 gives immediate zero outputs; after release, LW 0x20 returns the old value.
- LATENCY=1: ready on the cycle after the request; Wen and MemRead both high performs the store and returns ReadData 0.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder for the DM_* handshake: accepts a load/store, waits LATENCY
// cycles, then performs the aligned byte/half/word RAM access and pulses ready.
module dm_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_DM_Addr,
  input  logic [31:0] i_DM_Wd,
  input  logic [2:0]  i_DM_f3,
  input  logic        i_DM_Wen,
  input  logic        i_DM_MemRead,
  output logic        o_DM_data_ready,
  output logic [31:0] o_DM_ReadData,
  output logic        o_err
);
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [2:0]  f3_q;
  logic        st_q;
  logic [31:0] mem_q [MEM_WORDS];

  logic             req;
  logic [31:0]      addr_d;
  logic [31:0]      wd_d;
  logic [2:0]       f3_d;
  logic             st_d;
  logic [31:0]      off_d;
  logic [IDX_W-1:0] idx_d;
  logic             ill_d;
  logic             mis_d;
  logic             oor_d;
  logic             err_d;
  logic [3:0]       be_d;
  logic [31:0]      wsh_d;
  logic [31:0]      word_d;
  logic [31:0]      load_d;
  logic             enter_resp_d;
  logic             we_d;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b100:  r = {24'h0, w[7:0]};
      3'b101:  r = {16'h0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign req = i_DM_Wen | i_DM_MemRead;

  // In IDLE the access is decoded from the live inputs (only used when LATENCY=1),
  // afterwards from the latched request.
  always_comb begin
    addr_d = addr_q;
    wd_d   = wd_q;
    f3_d   = f3_q;
    st_d   = st_q;
    if (state_q == S_IDLE) begin
      addr_d = i_DM_Addr;
      wd_d   = i_DM_Wd;
      f3_d   = i_DM_f3;
      st_d   = i_DM_Wen;
    end
  end

  always_comb begin
    off_d = addr_d - BASE_ADDR;
    idx_d = off_d[IDX_W+1:2];
    oor_d = (off_d >= MEM_BYTES);
    ill_d = 1'b0;
    mis_d = 1'b0;
    be_d  = 4'b0000;
    case (f3_d)
      3'b000: be_d = 4'b0001 << addr_d[1:0];
      3'b001: begin
        be_d  = 4'b0011 << addr_d[1:0];
        mis_d = addr_d[0];
      end
      3'b010: begin
        be_d  = 4'b1111;
        mis_d = (addr_d[1:0] != 2'b00);
      end
      3'b100: ill_d = st_d;
      3'b101: begin
        ill_d = st_d;
        mis_d = addr_d[0];
      end
      default: ill_d = 1'b1;
    endcase
    err_d        = ill_d | mis_d | oor_d;
    wsh_d        = wd_d << {addr_d[1:0], 3'b000};
    word_d       = mem_q[idx_d];
    load_d       = load_extend(word_d >> {addr_d[1:0], 3'b000}, f3_d);
    enter_resp_d = req && (((state_q == S_IDLE) && (LATENCY == 1)) ||
                           ((state_q == S_WAIT) && (cnt_q == 4'd1)));
    we_d         = enter_resp_d & st_d & ~err_d & i_rst;
  end

  // Writes land only on the edge into RESP; the array itself carries no reset.
  always_ff @(posedge i_clk) begin
    if (we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[idx_d][8*b +: 8] <= wsh_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if ((state_q == S_IDLE) && req) begin
      addr_q <= i_DM_Addr;
      wd_q   <= i_DM_Wd;
      f3_q   <= i_DM_f3;
      st_q   <= i_DM_Wen;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (LATENCY == 1) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (enter_resp_d) begin
        ready_q <= 1'b1;
        err_q   <= err_d;
        rdata_q <= (!st_d && !err_d) ? load_d : 32'h0;
      end
    end
  end

  assign o_DM_data_ready = ready_q;
  assign o_DM_ReadData   = rdata_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Randomised bench for dm_responder against a byte-addressed little-endian memory
// model; a second instance covers LATENCY=1 with a non-zero base address.
module tb_dm_responder;
  localparam int unsigned MW  = 1024;
  localparam logic [31:0] BA  = 32'h0000_0000;
  localparam int unsigned MWB = 64;
  localparam logic [31:0] BAB = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_addr, a_wd, a_rdata;
  logic [2:0]  a_f3;
  logic        a_wen, a_rd, a_rdy, a_err;
  logic [31:0] b_addr, b_wd, b_rdata;
  logic [2:0]  b_f3;
  logic        b_wen, b_rd, b_rdy, b_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem_a [0:MW*4-1];
  logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  dm_responder #(.MEM_WORDS(MW), .BASE_ADDR(BA), .LATENCY(2)) u_dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_DM_Addr(a_addr), .i_DM_Wd(a_wd), .i_DM_f3(a_f3),
    .i_DM_Wen(a_wen), .i_DM_MemRead(a_rd), .o_DM_data_ready(a_rdy),
    .o_DM_ReadData(a_rdata), .o_err(a_err));

  dm_responder #(.MEM_WORDS(MWB), .BASE_ADDR(BAB), .LATENCY(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_DM_Addr(b_addr), .i_DM_Wd(b_wd), .i_DM_f3(b_f3),
    .i_DM_Wen(b_wen), .i_DM_MemRead(b_rd), .o_DM_data_ready(b_rdy),
    .o_DM_ReadData(b_rdata), .o_err(b_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte array, size from funct3, alignment by modulo, extension by masking.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output bit err, output logic [31:0] rd);
    int unsigned off, size;
    logic [31:0] v;
    off = addr - BA;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    err = (size == 0) || (st && f3[2]) || (off >= MW * 4) || ((size != 0) && (addr % size != 0));
    rd  = 32'h0;
    if (err) return;
    if (st) begin
      for (int i = 0; i < int'(size); i++) mem_a[off + i] = 8'((wd >> (8 * i)) & 32'hFF);
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(size); i++) v = v | (32'(mem_a[off + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic acc_a(input bit wen, input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] got);
    bit e_err, seen;
    logic [31:0] e_rd;
    int cyc;
    model(wen, f3, addr, wd, e_err, e_rd);
    a_wen = wen; a_rd = rd; a_f3 = f3; a_addr = addr; a_wd = wd;
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (a_rdy) seen = 1;
    end
    a_wen = 0; a_rd = 0;
    chk("a.ready_seen", 32'(seen), 32'd1);
    chk("a.latency", cyc, 32'd2);
    chk($sformatf("a.rdata@%h", addr), a_rdata, e_rd);
    chk($sformatf("a.err@%h", addr), 32'(a_err), 32'(e_err));
    got = a_rdata;
    @(negedge clk);
    chk("a.pulse_width", 32'(a_rdy), 32'd0);
    chk("a.rdata_idle", a_rdata, 32'd0);
  endtask

  task automatic acc_b(input string tag, input bit wen, input bit rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] e_rd, input bit e_err);
    bit seen;
    int cyc;
    b_wen = wen; b_rd = rd; b_f3 = f3; b_addr = addr; b_wd = wd;
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (b_rdy) seen = 1;
    end
    b_wen = 0; b_rd = 0;
    chk({tag, ".ready_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, cyc, 32'd1);
    chk({tag, ".rdata"}, b_rdata, e_rd);
    chk({tag, ".err"}, 32'(b_err), 32'(e_err));
    @(negedge clk);
    chk({tag, ".pulse_width"}, 32'(b_rdy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, e_rd, wdata;
    bit e_err, seen;
    int cyc, pulses;
    int t_p [3];

    rst_n = 0;
    a_addr = 0; a_wd = 0; a_f3 = 0; a_wen = 0; a_rd = 0;
    b_addr = 0; b_wd = 0; b_f3 = 0; b_wen = 0; b_rd = 0;
    repeat (3) @(negedge clk);
    chk("reset.ready", 32'(a_rdy), 32'd0);
    chk("reset.rdata", a_rdata, 32'd0);
    chk("reset.err", 32'(a_err), 32'd0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) acc_a(1, 0, 3'b010, 32'(i * 4), $urandom, got);

    acc_a(1, 0, 3'b010, 32'h10, 32'hDEADBEEF, got);
    acc_a(0, 1, 3'b010, 32'h10, 32'h0, got);
    chk("plan.lw", got, 32'hDEADBEEF);
    acc_a(0, 1, 3'b000, 32'h13, 32'h0, got);
    chk("plan.lb", got, 32'hFFFFFFDE);
    acc_a(0, 1, 3'b100, 32'h13, 32'h0, got);
    chk("plan.lbu", got, 32'h000000DE);
    acc_a(0, 1, 3'b001, 32'h12, 32'h0, got);
    chk("plan.lh", got, 32'hFFFFDEAD);
    acc_a(0, 1, 3'b101, 32'h10, 32'h0, got);
    chk("plan.lhu", got, 32'h0000BEEF);
    acc_a(1, 0, 3'b000, 32'h11, 32'h55, got);
    acc_a(0, 1, 3'b010, 32'h10, 32'h0, got);
    chk("plan.sb_lw", got, 32'hDEAD55EF);

    acc_a(0, 1, 3'b001, 32'h11, 32'h0, got);
    acc_a(1, 0, 3'b010, 32'h12, 32'h12345678, got);
    acc_a(0, 1, 3'b010, 32'(MW * 4), 32'h0, got);
    acc_a(0, 1, 3'b011, 32'h10, 32'h0, got);
    acc_a(1, 0, 3'b101, 32'h10, 32'h0000FFFF, got);
    acc_a(0, 1, 3'b010, 32'h10, 32'h0, got);
    chk("plan.err_ram_kept", got, 32'hDEAD55EF);

    // Request held high across three loads, address advanced on each ready.
    a_rd = 1; a_f3 = 3'b010; a_addr = 32'h20;
    pulses = 0; cyc = 0;
    while (cyc < 16) begin
      @(negedge clk);
      cyc++;
      if (a_rdy) begin
        model(0, 3'b010, a_addr, 32'h0, e_err, e_rd);
        chk($sformatf("b2b.rdata%0d", pulses), a_rdata, e_rd);
        if (pulses < 3) t_p[pulses] = cyc;
        pulses++;
        if (pulses < 3) a_addr = a_addr + 32'd4;
        else a_rd = 0;
      end
    end
    a_rd = 0;
    chk("b2b.pulses", pulses, 32'd3);
    chk("b2b.first", t_p[0], 32'd2);
    chk("b2b.gap1", t_p[1] - t_p[0], 32'd3);
    chk("b2b.gap2", t_p[2] - t_p[1], 32'd3);

    // Store withdrawn in its first WAIT cycle.
    a_wen = 1; a_f3 = 3'b010; a_addr = 32'h30; a_wd = 32'hA5A5A5A5;
    @(negedge clk);
    a_wen = 0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_rdy) pulses++;
    end
    chk("withdraw.pulses", pulses, 32'd0);
    model(0, 3'b010, 32'h30, 32'h0, e_err, e_rd);
    acc_a(0, 1, 3'b010, 32'h30, 32'h0, got);
    chk("withdraw.ram_kept", got, e_rd);

    // Reset while the ready pulse is up clears outputs asynchronously.
    a_rd = 1; a_f3 = 3'b010; a_addr = 32'h10;
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (a_rdy) seen = 1;
    end
    chk("rst_resp.ready_seen", 32'(seen), 32'd1);
    rst_n = 0; a_rd = 0;
    #1;
    chk("rst_resp.ready", 32'(a_rdy), 32'd0);
    chk("rst_resp.rdata", a_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Reset during WAIT of a store: nothing is written.
    a_wen = 1; a_f3 = 3'b010; a_addr = 32'h20; a_wd = 32'h0BADF00D;
    @(negedge clk);
    rst_n = 0; a_wen = 0;
    #1;
    chk("rst_wait.ready", 32'(a_rdy), 32'd0);
    chk("rst_wait.err", 32'(a_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    model(0, 3'b010, 32'h20, 32'h0, e_err, e_rd);
    acc_a(0, 1, 3'b010, 32'h20, 32'h0, got);
    chk("rst_wait.ram_kept", got, e_rd);

    for (int k = 0; k < 60; k++) begin
      int sel;
      bit w, r;
      logic [2:0] f;
      logic [31:0] ad;
      sel = $urandom_range(0, 9);
      w = (sel < 4);
      r = (sel >= 3);
      f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      ad = ($urandom_range(0, 9) == 0) ? 32'(MW * 4) + 32'($urandom_range(0, 15))
                                        : 32'($urandom_range(0, 63));
      wdata = $urandom;
      acc_a(w, r, f, ad, wdata, got);
    end

    acc_b("l1.both_high", 1, 1, 3'b010, 32'h1010, 32'hCAFEF00D, 32'h0, 0);
    acc_b("l1.lw", 0, 1, 3'b010, 32'h1010, 32'h0, 32'hCAFEF00D, 0);
    acc_b("l1.lb", 0, 1, 3'b000, 32'h1011, 32'h0, 32'hFFFFFFF0, 0);
    acc_b("l1.oor_hi", 0, 1, 3'b010, 32'h1100, 32'h0, 32'h0, 1);
    acc_b("l1.oor_lo", 0, 1, 3'b010, 32'h0FFC, 32'h0, 32'h0, 1);
    acc_b("l1.sh_mis", 1, 0, 3'b001, 32'h1013, 32'hFFFF, 32'h0, 1);
    acc_b("l1.lw_kept", 0, 1, 3'b010, 32'h1010, 32'h0, 32'hCAFEF00D, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
